// File: rtl/ram64_loader_pkg.sv
// ram64_loader_pkg: shared sizes and FSM state encoding for the RAM loader
package ram64_loader_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 6;
  localparam int RAM_DEPTH = 1 << DEF_ADDR_W;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/sum16_acc.sv
// sum16_acc: registered wraparound accumulator with clear and enable
module sum16_acc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum
);
  always_ff @(posedge clk)
    if (reset || clr) sum <= '0;
    else if (en) sum <= sum + d;
endmodule

// File: rtl/ram64_loader.sv
// ram64_loader: streams words into a RAM window at base (wrapping) and verifies them by checksum readback
module ram64_loader
  import ram64_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              mismatch
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);
  state_t state, state_n;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0] len, idx, len_c;
  logic [DATA_W-1:0] wsum, rsum;
  logic accept, hs, last;
  assign len_c = length > DEPTH ? DEPTH : length;
  assign accept = state == IDLE && start;
  assign hs = state == WRITE && s_valid;
  assign last = idx == len - (ADDR_W+1)'(1);
  assign s_ready = state == WRITE;
  assign ram_load = hs;
  assign ram_in = state == WRITE ? s_data : '0;
  assign ram_address = (state == WRITE || state == VERIFY) ? base + idx[ADDR_W-1:0] : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb
    state_n = state == IDLE   ? (start ? (len_c == '0 ? DONE : WRITE) : IDLE) :
              state == WRITE  ? (hs && last ? VERIFY : WRITE) :
              state == VERIFY ? (last ? DONE : VERIFY) : IDLE;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      base     <= '0;
      len      <= '0;
      idx      <= '0;
      checksum <= '0;
      mismatch <= 1'b0;
    end else if (accept) begin
      base     <= base_addr;
      len      <= len_c;
      idx      <= '0;
      checksum <= '0;
      mismatch <= 1'b0;
    end else if (hs) idx <= last ? '0 : idx + (ADDR_W+1)'(1);
    else if (state == VERIFY) idx <= idx + (ADDR_W+1)'(1);
    else if (state == DONE) begin
      checksum <= wsum;
      mismatch <= wsum != rsum;
    end
  sum16_acc #(.W(DATA_W)) u_wsum (
    .clk(clk), .reset(reset), .clr(accept), .en(hs), .d(s_data), .sum(wsum)
  );
  sum16_acc #(.W(DATA_W)) u_rsum (
    .clk(clk), .reset(reset), .clr(accept), .en(state == VERIFY), .d(ram_out), .sum(rsum)
  );
endmodule

// File: tb/tb_ram64_loader.sv
// tb_ram64_loader: directed tests of the loader against a behavioural 64-word RAM
module tb_ram64_loader;
  logic clk = 0;
  logic reset = 1;
  logic start = 0;
  logic [5:0] base_addr = 0;
  logic [6:0] length = 0;
  logic s_valid = 0;
  logic [15:0] s_data = 0;
  logic s_ready, ram_load, busy, done, mismatch;
  logic [15:0] ram_in, ram_out, checksum;
  logic [5:0] ram_address;
  logic [15:0] mem [64];
  logic force_en = 0;
  int cyc = 0, nload = 0, t0 = 0, lat = 0, n_chk = 0, n_fail = 0;

  ram64_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .ram_in(ram_in),
    .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out), .busy(busy),
    .done(done), .checksum(checksum), .mismatch(mismatch)
  );

  always #5 clk = ~clk;
  assign ram_out = force_en ? 16'h0000 : mem[ram_address];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_load) begin
      mem[ram_address] <= ram_in;
      nload <= nload + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [5:0] b, input logic [6:0] l);
    start = 1;
    base_addr = b;
    length = l;
    tick();
    start = 0;
    t0 = cyc;
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    s_valid = 1;
    s_data = d;
    tick();
    s_valid = 0;
    repeat (gap) tick();
  endtask

  task automatic wait_done();
    while (!done && cyc - t0 < 300) tick();
    lat = cyc - t0 + 1;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    n_chk++;
    if ({busy, done, s_ready, ram_load, mismatch} !== 5'b0 || checksum !== 16'h0 || ram_address !== 6'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b rdy=%b load=%b mm=%b cs=%h addr=%0d, required all 0",
               busy, done, s_ready, ram_load, mismatch, checksum, ram_address);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp [4] = '{16'h1, 16'h2, 16'h3, 16'h4};
    start_job(6'd0, 7'd4);
    n_chk++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_write_state: s_ready=%b busy=%b, required 1 1", s_ready, busy);
    end
    for (int i = 0; i < 4; i++) send(exp[i], 0);
    wait_done();
    n_chk++;
    if (done !== 1'b1 || lat !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: done=%b cycle=%0d, required 1 at 9", done, lat);
    end
    tick();
    n_chk++;
    if (checksum !== 16'h000A || mismatch !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: cs=%h mm=%b done=%b busy=%b, required 000a 0 0 0", checksum, mismatch, done, busy);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (mem[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL basic_ram[%0d]: got %h, required %h", i, mem[i], exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int a [4] = '{62, 63, 0, 1};
    start_job(6'd62, 7'd4);
    for (int i = 0; i < 4; i++) send(16'hFFFF, 0);
    wait_done();
    tick();
    n_chk++;
    if (checksum !== 16'hFFFC || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_result: cs=%h mm=%b, required fffc 0", checksum, mismatch);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (mem[a[i]] !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL wrap_ram[%0d]: got %h, required ffff", a[i], mem[a[i]]);
      end
    end
    n_chk++;
    if (mem[2] !== 16'h0003) begin
      n_fail++;
      $display("FAIL wrap_untouched[2]: got %h, required 0003", mem[2]);
    end
  endtask

  task automatic test_gaps();
    int n0;
    n0 = nload;
    start_job(6'd40, 7'd3);
    send(16'h0100, 2);
    n_chk++;
    if (ram_load !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_stall: load=%b rdy=%b, required 0 1", ram_load, s_ready);
    end
    send(16'h0020, 2);
    send(16'h0003, 0);
    wait_done();
    n_chk++;
    if (done !== 1'b1 || lat !== 11) begin
      n_fail++;
      $display("FAIL gaps_latency: done=%b cycle=%0d, required 1 at 11", done, lat);
    end
    tick();
    n_chk++;
    if (nload - n0 !== 3 || checksum !== 16'h0123 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_result: loads=%0d cs=%h mm=%b, required 3 0123 0", nload - n0, checksum, mismatch);
    end
    n_chk++;
    if (mem[40] !== 16'h0100 || mem[41] !== 16'h0020 || mem[42] !== 16'h0003) begin
      n_fail++;
      $display("FAIL gaps_ram: got %h %h %h, required 0100 0020 0003", mem[40], mem[41], mem[42]);
    end
  endtask

  task automatic test_mismatch();
    start_job(6'd5, 7'd1);
    send(16'h1234, 0);
    force_en = 1;
    wait_done();
    force_en = 0;
    tick();
    n_chk++;
    if (checksum !== 16'h1234 || mismatch !== 1'b1 || mem[5] !== 16'h1234) begin
      n_fail++;
      $display("FAIL mismatch_result: cs=%h mm=%b ram5=%h, required 1234 1 1234", checksum, mismatch, mem[5]);
    end
    repeat (3) tick();
    n_chk++;
    if (checksum !== 16'h1234 || mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch_hold: cs=%h mm=%b, required 1234 1", checksum, mismatch);
    end
  endtask

  task automatic test_mid_reset();
    start_job(6'd10, 7'd6);
    send(16'hAAAA, 0);
    send(16'h5555, 0);
    s_valid = 1;
    s_data = 16'h7777;
    reset = 1;
    tick();
    reset = 0;
    s_valid = 0;
    n_chk++;
    if ({busy, done, s_ready, ram_load, mismatch} !== 5'b0 || checksum !== 16'h0 || ram_address !== 6'h0 || ram_in !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset_state: busy=%b done=%b rdy=%b load=%b mm=%b cs=%h addr=%0d in=%h, required all 0",
               busy, done, s_ready, ram_load, mismatch, checksum, ram_address, ram_in);
    end
    n_chk++;
    if (mem[10] !== 16'hAAAA || mem[11] !== 16'h5555) begin
      n_fail++;
      $display("FAIL midreset_ram: got %h %h, required aaaa 5555", mem[10], mem[11]);
    end
    start_job(6'd20, 7'd2);
    send(16'h0100, 0);
    send(16'h0200, 0);
    wait_done();
    n_chk++;
    if (done !== 1'b1 || lat !== 5) begin
      n_fail++;
      $display("FAIL midreset_rerun_latency: done=%b cycle=%0d, required 1 at 5", done, lat);
    end
    tick();
    n_chk++;
    if (checksum !== 16'h0300 || mismatch !== 1'b0 || mem[20] !== 16'h0100 || mem[21] !== 16'h0200) begin
      n_fail++;
      $display("FAIL midreset_rerun: cs=%h mm=%b ram=%h %h, required 0300 0 0100 0200", checksum, mismatch, mem[20], mem[21]);
    end
  endtask

  task automatic test_empty_and_busy_start();
    int n0;
    n0 = nload;
    start_job(6'd7, 7'd0);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: done=%b busy=%b rdy=%b, required 1 1 0", done, busy, s_ready);
    end
    tick();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || checksum !== 16'h0 || mismatch !== 1'b0 || nload !== n0) begin
      n_fail++;
      $display("FAIL empty_result: done=%b busy=%b cs=%h mm=%b loads=%0d, required 0 0 0000 0 0",
               done, busy, checksum, mismatch, nload - n0);
    end
    start_job(6'd30, 7'd2);
    send(16'h0011, 0);
    start = 1;
    base_addr = 6'd50;
    length = 7'd5;
    send(16'h0022, 0);
    start = 0;
    wait_done();
    n_chk++;
    if (done !== 1'b1 || lat !== 5) begin
      n_fail++;
      $display("FAIL busy_start_latency: done=%b cycle=%0d, required 1 at 5", done, lat);
    end
    tick();
    n_chk++;
    if (checksum !== 16'h0033 || mem[30] !== 16'h0011 || mem[31] !== 16'h0022 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_result: cs=%h ram=%h %h busy=%b, required 0033 0011 0022 0", checksum, mem[30], mem[31], busy);
    end
  endtask

  task automatic test_full_clamp();
    start_job(6'd0, 7'd100);
    for (int i = 0; i < 64; i++) send(16'(i + 1), 0);
    n_chk++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_verify_state: rdy=%b busy=%b, required 0 1", s_ready, busy);
    end
    wait_done();
    n_chk++;
    if (done !== 1'b1 || lat !== 129) begin
      n_fail++;
      $display("FAIL clamp_latency: done=%b cycle=%0d, required 1 at 129", done, lat);
    end
    tick();
    n_chk++;
    if (checksum !== 16'h0820 || mismatch !== 1'b0 || mem[0] !== 16'h0001 || mem[63] !== 16'h0040) begin
      n_fail++;
      $display("FAIL clamp_result: cs=%h mm=%b ram0=%h ram63=%h, required 0820 0 0001 0040", checksum, mismatch, mem[0], mem[63]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_mismatch();
    test_mid_reset();
    test_empty_and_busy_start();
    test_full_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram64_loader.md
# ram64_loader

Sequencing stage directly upstream of the 64-word RAM: accepts a valid/ready stream of 16-bit words and writes them into consecutive RAM addresses starting at a programmed base, wrapping modulo 64. It then reads the same window back through the RAM's combinational output and compares a 16-bit additive checksum of the written data against that of the readback. It drives the RAM's `in`/`load`/`address` inputs and observes its `out`; used for boot-time image loading and memory self-test.

## Interface
- `DATA_W`, 16, word width (matches RAM word)
- `ADDR_W`, 6, RAM address width; depth = 2^ADDR_W = 64
- `clk` input 1 — single clock, rising edge
- `reset` input 1 — synchronous, active-high
- `start` input 1 — begin a load; sampled only in IDLE
- `base_addr` input ADDR_W — first write address, latched on accepted `start`
- `length` input ADDR_W+1 — words to load, latched on accepted `start`; 0 = empty job; values >64 clamp to 64
- `s_valid` input 1 — stream word valid
- `s_data` input DATA_W — stream word
- `s_ready` output 1 — loader can accept a word
- `ram_in` output DATA_W — to RAM `in`
- `ram_load` output 1 — to RAM `load`
- `ram_address` output ADDR_W — to RAM `address`
- `ram_out` input DATA_W — from RAM `out` (combinational read)
- `busy` output 1 — high outside IDLE
- `done` output 1 — one-cycle pulse at job end
- `checksum` output DATA_W — sum mod 2^16 of words written by last job; held until next accepted `start`
- `mismatch` output 1 — write sum ≠ readback sum for last job; held until next accepted `start`

## Operation
- States: IDLE, WRITE, VERIFY, DONE.
- IDLE: `s_ready`=0, `ram_load`=0. `start`=1 → latch base, clamped length; clear idx, wsum, rsum, `checksum`, `mismatch`. Next state WRITE if length≠0, else DONE.
- WRITE: `s_ready`=1; `ram_address`=(base+idx) mod 64; `ram_in`=`s_data`; `ram_load`=`s_valid` (combinational). On handshake (`s_valid`&`s_ready`): wsum+=`s_data` (mod 2^16), idx++. Handshake on last word (idx=len−1) → VERIFY, idx←0. `s_valid`=0 stalls without side effects.
- VERIFY: `ram_load`=0, `s_ready`=0; `ram_address`=(base+idx) mod 64; each cycle rsum+=`ram_out`, idx++; after len cycles → DONE.
- DONE: `done`=1 for exactly one cycle; `checksum`←wsum, `mismatch`←(wsum≠rsum); → IDLE. Empty job: checksum 0, mismatch 0.
- Wrap: base=60, len=8 writes 60..63, 0..3. len=64 covers all of RAM once; no address written twice per job.
- `start` while busy: ignored, no effect on job.
- `reset` (any state, including mid-WRITE): next edge → IDLE; `busy`,`done`,`s_ready`,`ram_load`,`mismatch`=0, `checksum`=0, `ram_address`=0, `ram_in`=0. RAM words already written stay written.

## Timing
- `ram_load`/`ram_in`/`ram_address` are combinational from state, idx and stream; RAM captures on the same edge as the handshake.
- Word accepted at edge k is visible on `ram_out` from edge k onward.
- Zero-bubble job of N words: start edge, N WRITE cycles, N VERIFY cycles, 1 DONE cycle → `done` high in cycle 2N+1 after the start edge; `busy` high for 2N+1 cycles.
- Empty job: `done` the cycle after start; `busy` one cycle.
- `s_ready` never depends on `s_valid`.

## Structure
- Shared package: state encoding localparams, `RAM_DEPTH`=64, `DATA_W`/`ADDR_W` defaults.
- One sub-module `sum16_acc` (clear, enable, 16-bit data, registered wraparound sum), instantiated twice for wsum and rsum.
- Address = base + idx truncated to ADDR_W bits; idx is ADDR_W+1 bits wide to hold 64.

## Test plan
- base=0, len=4, stream 0x0001,0x0002,0x0003,0x0004 no gaps → RAM[0..3] hold those; checksum 0x000A, mismatch 0, `done` 9 cycles after start edge.
- base=62, len=4, data 0xFFFF×4 → RAM[62],[63],[0],[1]=0xFFFF; checksum 0xFFFC (wraps), mismatch 0.
- len=3 with `s_valid` low 2 cycles between words → `ram_load` only on valid cycles, correct contents, `done` delayed by 4 cycles.
- Force RAM word at address 5 to 0x0000 during VERIFY (bench override of `ram_out`) for base=5, len=1, data 0x1234 → checksum 0x1234, mismatch 1.
- `reset` asserted after 2 of 6 words → next cycle IDLE, all outputs 0; RAM[base],[base+1] retain data; new start runs normally.
- len=0 → `done` 1 cycle later, no `ram_load`, checksum 0; `start` pulsed mid-job → ignored.
